// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: owns L/R, C/D, round counter and handshakes; 16 rounds per block.
// Optional macro DES_F_PIPE_EN: datapath has one register stage, each round takes ISSUE + CAPTURE cycles.
module des_round_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] block_in,
    input  logic [55:0] key_cd,
    output logic [31:0] right_out,
    output logic [55:0] cd_out,
    output logic [3:0]  round_idx,
    input  logic [31:0] f_result,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] block_out
);

    generate
        if (NUM_ROUNDS != 16) begin : g_bad_rounds
            $error("des_round_ctrl: NUM_ROUNDS must be 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic [63:0] out_q, out_d;
    logic        advance;
    logic        single_step;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [55:0] cd_rot(input logic [55:0] cd, input logic dec, input logic two);
        return dec ? {rotr(cd[55:28], two), rotr(cd[27:0], two)}
                   : {rotl(cd[55:28], two), rotl(cd[27:0], two)};
    endfunction

`ifdef DES_F_PIPE_EN
    // Phase 0 issues operands to the registered datapath, phase 1 consumes f_result.
    logic phase_q, phase_d;
    assign advance = phase_q;
`else
    assign advance = 1'b1;
`endif

    // Transition into round i+1 shifts by one for rounds 2, 9, 16 (encrypt) and 16, 9, 2 (decrypt).
    assign single_step = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        out_d   = out_q;
`ifdef DES_F_PIPE_EN
        phase_d = phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    l_d     = block_in[63:32];
                    r_d     = block_in[31:0];
                    dec_d   = decrypt;
                    cd_d    = decrypt ? key_cd : cd_rot(key_cd, 1'b0, 1'b0);
                    round_d = 4'd0;
                    state_d = S_ROUND;
`ifdef DES_F_PIPE_EN
                    phase_d = 1'b0;
`endif
                end
            end
            S_ROUND: begin
`ifdef DES_F_PIPE_EN
                phase_d = ~phase_q;
`endif
                if (advance) begin
                    l_d = r_q;
                    r_d = l_q ^ f_result;
                    if (round_q == 4'(NUM_ROUNDS - 1)) begin
                        out_d   = {l_q ^ f_result, r_q};
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        cd_d    = cd_rot(cd_q, dec_q, ~single_step);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            out_q   <= '0;
`ifdef DES_F_PIPE_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
`ifdef DES_F_PIPE_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ROUND);
    assign out_valid = (state_q == S_DONE);
    assign right_out = r_q;
    assign cd_out    = cd_q;
    assign round_idx = round_q;
    assign block_out = out_q;

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Iterative sequencer for the DES Feistel core.
- Accepts a post-IP 64-bit block and a post-PC-1 56-bit key, then runs 16 rounds over one shared round datapath (E expansion -> key XOR -> S-boxes -> P).
- Owns the L/R and C/D registers, the round counter, the per-round C/D rotation schedule (encrypt/decrypt) and the valid/ready handshakes.
- Presents the pre-output block (R16,L16) to the final-permutation stage.

Parameters:
- NUM_ROUNDS, 16, rounds per block. Only 16 is legal; any other value is a synthesis-time error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  block/key offered
- in_ready  out  1  controller can accept
- decrypt  in  1  0=encrypt, 1=decrypt; sampled on accept
- block_in  in  64  post-IP block: [63:32]=L0, [31:0]=R0
- key_cd  in  56  post-PC-1 key: [55:28]=C0, [27:0]=D0
- right_out  out  32  current R, drives the E function
- cd_out  out  56  current C/D, drives PC-2 for this round's subkey
- round_idx  out  4  0..15 = round 1..16
- f_result  in  32  f(R,K) returned by the datapath
- busy  out  1  high while in ROUND state
- out_valid  out  1  block_out valid
- out_ready  in  1  downstream accepts
- block_out  out  64  {R16,L16}, i.e. the final swap is applied

Behaviour:
- States:
  - IDLE: in_ready=1.
  - ROUND: busy=1.
  - DONE: out_valid=1.
- Reset: state=IDLE. L, R, CD, round_idx and the latched decrypt flag are all zero. in_ready=1, busy=0, out_valid=0, block_out=0.
- Reset asserted mid-ROUND or mid-DONE aborts the operation. Nothing is emitted and the in-flight block is discarded.
- Accept (IDLE & in_valid) loads L<=block_in[63:32], R<=block_in[31:0] and latches decrypt. Next state is ROUND with round_idx=0.
  - Encrypt: CD is loaded with each 28-bit half rotated left by 1 (K1 schedule).
  - Decrypt: CD is loaded with key_cd unrotated (K16 = C0D0).
- Rotation rules: rotl1(X)={X[26:0],X[27]} per half; rotr1(X)={X[0],X[27:1]}; C and D rotate independently.
- Shift table, s(n) for round n=1..16: s=1 for n in {1,2,9,16}; s=2 otherwise.
- ROUND cycle for round_idx=i:
  - The datapath is combinational on right_out/cd_out. f_result is valid in the same cycle.
  - Update: L<=R, R<=L^f_result.
  - If i<15: round_idx<=i+1. Encrypt rotates CD left by s(i+2); decrypt rotates CD right by s(16-i).
  - If i==15: block_out<={L^f_result, R}, i.e. {R16,L16}. Next state is DONE.
- Latency: accept at cycle 0, rounds on cycles 1..16, out_valid high from cycle 17.
- DONE:
  - out_valid and block_out hold until out_ready. Backpressure is unbounded.
  - On out_valid & out_ready, return to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- decrypt and key_cd changes after accept are ignored.
- in_valid while busy/DONE is ignored (in_ready=0).

Optional Feature:
- Macro: DES_F_PIPE_EN.
- Defined: the datapath has one register stage, and each round takes 2 cycles: ISSUE (drive right_out/cd_out), then CAPTURE (consume f_result).
  - right_out, cd_out and round_idx hold stable across both cycles.
  - out_valid rises at cycle 33 after accept.
  - Reset during either phase aborts as above.
- Undefined: single-cycle rounds as specified above.

Test Plan:
- Encrypt with f_result model = 0, block_in=64'h01234567_89ABCDEF, key_cd=0 -> busy cycles 1..16; out_valid at cycle 17; block_out=64'h89ABCDEF_01234567.
- Encrypt key schedule with key_cd=56'h0000001_0000001:
  - round_idx=0 -> cd_out=56'h0000002_0000002.
  - round_idx=1 -> cd_out=56'h0000004_0000004.
  - round_idx=2 -> cd_out=56'h0000010_0000010.
  - round_idx=15 -> cd_out=56'h0000001_0000001 (28 cumulative shifts).
- Decrypt with key_cd=56'h0000001_0000001:
  - round_idx=0 -> cd_out=56'h0000001_0000001.
  - round_idx=1 -> cd_out=56'h8000000_8000000.
  - round_idx=2 -> cd_out=56'h2000000_2000000.
- Model f_result=right_out^32'hFFFFFFFF, block_in=64'h0; a bench reference Feistel model must match block_out exactly. Hold out_ready=0 for 10 cycles -> out_valid and block_out stable; in_ready=0 throughout.
- Assert rst at round_idx=7 -> next cycle: IDLE, in_ready=1, out_valid=0, block_out=0. A fresh block then completes normally in 17 cycles.
- With DES_F_PIPE_EN defined, repeat test 1 -> out_valid at cycle 33; round_idx is held for 2 cycles each; block_out=64'h89ABCDEF_01234567.
